// File: rtl/cmp_seq.sv
// -----------------------------------------------------------------------------
// cmp_seq -- sequential magnitude comparator for multi-chunk operands.
//
// Two operands A and B arrive one W-bit chunk per transfer, least-significant
// chunk first. Chunk s_last marks the most significant chunk. The block tracks
// a running lt/eq/gt verdict. A differing chunk overrides whatever the lower
// chunks decided, and an equal chunk leaves the verdict alone, so the last
// differing (most significant) chunk wins. After the last chunk the verdict and
// the chunk count n are presented on the result side until they are consumed.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready are
// both high. A valid without the matching ready is ignored, and so is a ready
// without the matching valid. Once the source raises s_valid it holds
// s_a/s_b/s_last until the transfer completes. Once the block raises m_valid it
// holds lt/eq/gt/n until the transfer completes.
//
// Parameters
//   ORDER   chunk width W = 2**ORDER bits
//   SIGNED  1: the most significant chunk is compared as signed (two's
//           complement of the whole operand), 0: fully unsigned compare
//   CW      width of the chunk counter n (wraps modulo 2**CW)
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high reset
//   s_valid    chunk present on s_a/s_b/s_last
//   s_ready    block accepts a chunk (high in ACC)
//   s_a, s_b   operand chunks, W bits each
//   s_last     chunk is the most significant of the operand
//   m_valid    result valid (high in DONE)
//   m_ready    consumer accepts the result
//   lt/eq/gt   whole-operand verdict, exactly one is high
//   n          number of chunks in the compared operand
//   dbg_state  current FSM state (0 = ACC, 1 = DONE)
// -----------------------------------------------------------------------------
module cmp_seq #(
  parameter int ORDER  = 3,
  parameter int SIGNED = 0,
  parameter int CW     = 8,
  localparam int W     = 2 ** ORDER
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_a,
  input  logic [W-1:0]  s_b,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          lt,
  output logic          eq,
  output logic          gt,
  output logic [CW-1:0] n,
  output logic          dbg_state
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_m_valid;
  logic          r_lt;
  logic          r_eq;
  logic          r_gt;
  logic [CW-1:0] r_n;

  logic w_s_xfer;
  logic w_m_xfer;
  logic w_chunk_ne;
  logic w_chunk_lt;

  // Transfers are qualified by the registered state only, so nothing on the
  // input side reaches the result outputs without passing through a flop.
  assign w_s_xfer = s_valid & (r_state == ACC);
  assign w_m_xfer = m_ready & (r_state == DONE);

  assign w_chunk_ne = (s_a != s_b);

  // Only the most significant chunk carries the sign bit. Lower chunks of a
  // two's-complement number are plain unsigned digits.
  always_comb begin
    w_chunk_lt = (s_a < s_b);
    if ((SIGNED != 0) && s_last) begin
      w_chunk_lt = ($signed(s_a) < $signed(s_b));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ACC;
      r_m_valid <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b1;
      r_gt      <= 1'b0;
      r_n       <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_s_xfer) begin
            r_n <= r_n + CW'(1);
            // Equal chunks keep the verdict of the lower chunks.
            if (w_chunk_ne) begin
              r_lt <= w_chunk_lt;
              r_gt <= ~w_chunk_lt;
              r_eq <= 1'b0;
            end
            if (s_last) begin
              r_state   <= DONE;
              r_m_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (w_m_xfer) begin
            r_state   <= ACC;
            r_m_valid <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b1;
            r_gt      <= 1'b0;
            r_n       <= '0;
          end
        end
        default: begin
          r_state   <= ACC;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid   = r_m_valid;
  assign s_ready   = ~r_m_valid;
  assign lt        = r_lt;
  assign eq        = r_eq;
  assign gt        = r_gt;
  assign n         = r_n;
  assign dbg_state = r_state;

endmodule

// File: doc/cmp_seq.md
CMP_SEQ -- requirements
Module: cmp_seq

Interface
REQ-001 SHALL have parameter ORDER, default 3, giving chunk width W = 2**ORDER bits.
REQ-002 SHALL have parameter SIGNED, default 0; 1 = two's-complement compare of the full operand.
REQ-003 SHALL have parameter CW, default 8, giving chunk-counter width.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  chunk present on s_a/s_b/s_last.
REQ-007 SHALL have port s_ready  output  1  block accepts a chunk this cycle.
REQ-008 SHALL have port s_a  input  W  operand A chunk, least-significant chunk first.
REQ-009 SHALL have port s_b  input  W  operand B chunk, same position as s_a.
REQ-010 SHALL have port s_last  input  1  chunk is the most significant of the operand.
REQ-011 SHALL have port m_valid  output  1  result on lt/eq/gt/n is valid.
REQ-012 SHALL have port m_ready  input  1  consumer accepts the result.
REQ-013 SHALL have ports lt, eq, gt  output  1 each  A<B, A==B, A>B for the whole operand.
REQ-014 SHALL have port n  output  CW  number of chunks in the compared operand.

Function
REQ-015 Chunk transfer SHALL occur when s_valid & s_ready are high at a clock edge; result transfer SHALL occur when m_valid & m_ready are high.
REQ-016 SHALL use two states: ACC (s_ready=1, m_valid=0) and DONE (s_ready=0, m_valid=1); s_ready SHALL equal ~m_valid.
REQ-017 In ACC, on a non-last transfer, if s_a!=s_b the running state SHALL take the unsigned chunk result (lt=s_a<s_b, gt=s_a>s_b, eq=0); if s_a==s_b it SHALL be unchanged.
REQ-018 On a last transfer, the same rule SHALL apply; with SIGNED=1 the last chunk SHALL be compared as signed W-bit values.
REQ-019 A last transfer SHALL move to DONE, so m_valid is high on the following cycle (latency 1 cycle after the last chunk).
REQ-020 n SHALL count accepted chunks including the last; it SHALL wrap modulo 2**CW without error.
REQ-021 In DONE, lt/eq/gt/n SHALL hold stable until the result transfer.
REQ-022 On a result transfer the block SHALL return to ACC with lt=0, eq=1, gt=0, n=0 on the next cycle.
REQ-023 Exactly one of lt/eq/gt SHALL be high at all times.
REQ-024 s_valid with s_ready low SHALL be ignored, and m_ready with m_valid low SHALL be ignored.
REQ-025 A single-chunk operand (s_last on the first chunk) SHALL be legal and produce n=1.
REQ-026 The implementation SHALL be 120-400 lines of synthesizable RTL with no combinational path from s_* to m_*.

Reset
REQ-027 While reset is high, the block SHALL hold state ACC, m_valid=0, s_ready=1, lt=0, eq=1, gt=0, n=0, independent of clock.
REQ-028 Reset asserted mid-operand or in DONE SHALL discard the partial or pending result; the first transfer after deassertion SHALL start a new operand.

Verification
REQ-029 SHALL test ORDER=3, SIGNED=0: chunks (a,b) = (0x12,0x34), (0x56,0x56) last -> m_valid next cycle, lt=1, eq=0, gt=0, n=2.
REQ-030 SHALL test equality: 3 chunks all equal, last on the third -> eq=1, n=3; with m_ready=0 for 5 cycles, outputs stay stable and s_ready=0.
REQ-031 SHALL test SIGNED=1: single chunk a=0x80, b=0x01, last -> lt=1; the same stimulus with SIGNED=0 -> gt=1.
REQ-032 SHALL test high-chunk dominance: (0xFF,0x00), (0x00,0x01) last -> lt=1.
REQ-033 SHALL test reset asynchronously mid-operand after 1 chunk: immediately m_valid=0, eq=1, n=0; a new single chunk (0x05,0x03) last -> gt=1, n=1.
REQ-034 SHALL test back-to-back operation: m_ready held high, two operands streamed -> two results, and no chunk is accepted during the DONE cycle.
